// File: rtl/alu_divider_u_if.sv
// Operand/result and start/busy/done handshake bundle for the alu_divider_u divider.
interface alu_divider_u_if #(
  parameter int DIVW = 32
);
  logic            div_start;
  logic [DIVW-1:0] div_a;
  logic [DIVW-1:0] div_b;
  logic            div_signed;
  logic [DIVW-1:0] quot;
  logic [DIVW-1:0] rem;
  logic            div_busy;
  logic            div_done;
  logic            div_by_zero;

  modport master (
    output div_start, div_a, div_b, div_signed,
    input  quot, rem, div_busy, div_done, div_by_zero
  );

  modport slave (
    input  div_start, div_a, div_b, div_signed,
    output quot, rem, div_busy, div_done, div_by_zero
  );
endinterface

// File: rtl/alu_divider_u.sv
// Iterative restoring divider (one quotient bit per clock) for the ALU DIV/MOD slots.
// Optional signed operation is enabled by defining DIV_SIGNED_EN.
module alu_divider_u #(
  parameter int DIVW = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_divider_u_if.slave bus
);
  localparam int CW = $clog2(DIVW + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [DIVW-1:0] dvd_r, dvs_r, rem_r;
  logic [CW-1:0]   cnt_r;
  logic [DIVW-1:0] quot_r, rem_out_r;
  logic            dbz_r;

  logic            accept, b_zero, last;
  logic [DIVW-1:0] a_mag, b_mag;
  logic [DIVW:0]   rem_sh, diff;
  logic            fits;
  logic [DIVW-1:0] rem_nxt, quo_nxt, q_fin, r_fin;

  assign accept = bus.div_start && (state != RUN);
  assign b_zero = (bus.div_b == '0);
  assign last   = (state == RUN) && (cnt_r == CW'(1));

`ifdef DIV_SIGNED_EN
  logic a_neg, b_neg, neg_q_r, neg_r_r;
  assign a_neg = bus.div_signed && bus.div_a[DIVW-1];
  assign b_neg = bus.div_signed && bus.div_b[DIVW-1];
  // Most-negative maps onto itself, which is its correct unsigned magnitude.
  assign a_mag = a_neg ? -bus.div_a : bus.div_a;
  assign b_mag = b_neg ? -bus.div_b : bus.div_b;
  assign q_fin = neg_q_r ? -quo_nxt : quo_nxt;
  assign r_fin = neg_r_r ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept) begin
      neg_q_r <= a_neg ^ b_neg;
      neg_r_r <= a_neg;
    end
  end
`else
  logic unused_signed;
  assign unused_signed = bus.div_signed;
  assign a_mag = bus.div_a;
  assign b_mag = bus.div_b;
  assign q_fin = quo_nxt;
  assign r_fin = rem_nxt;
`endif

  // One restoring step: the extra top bit of the shifted remainder catches the borrow.
  assign rem_sh  = {rem_r, dvd_r[DIVW-1]};
  assign diff    = rem_sh - {1'b0, dvs_r};
  assign fits    = !diff[DIVW];
  assign rem_nxt = fits ? diff[DIVW-1:0] : rem_sh[DIVW-1:0];
  assign quo_nxt = {dvd_r[DIVW-2:0], fits};

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = b_zero ? DONE : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.div_busy = 1'b0;
    bus.div_done = 1'b0;
    unique case (state)
      RUN:     bus.div_busy = 1'b1;
      DONE:    bus.div_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      rem_r     <= '0;
      cnt_r     <= '0;
      quot_r    <= '0;
      rem_out_r <= '0;
      dbz_r     <= 1'b0;
    end else if (accept) begin
      dvd_r <= a_mag;
      dvs_r <= b_mag;
      rem_r <= '0;
      cnt_r <= CW'(DIVW);
      if (b_zero) begin
        quot_r    <= '1;
        rem_out_r <= bus.div_a;
        dbz_r     <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd_r <= quo_nxt;
      rem_r <= rem_nxt;
      cnt_r <= cnt_r - CW'(1);
      if (last) begin
        quot_r    <= q_fin;
        rem_out_r <= r_fin;
        dbz_r     <= 1'b0;
      end
    end
  end

  assign bus.quot        = quot_r;
  assign bus.rem         = rem_out_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_alu_divider_u.sv
// Self-checking bench for alu_divider_u: per-cycle reference model plus directed literal checks.
module tb_alu_divider_u;
  localparam int W = 32;
  localparam logic [W-1:0] ONES = '1;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_divider_u_if #(.DIVW(W)) bus ();
  alu_divider_u #(.DIVW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic: what an operation must return, from the operand values alone.
  function automatic void model_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
    longint sa, sb;
    z = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == '0) begin
      q = ONES; r = a; z = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (s) begin
      if (a == MINV && b == ONES) begin
        q = MINV; r = '0;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
    end
`endif
    else begin
      if (s && sa == sb) q = 1; // unsigned view ignores the flag; both branches agree
      q = a / b;
      r = a % b;
    end
  endfunction

  // Observable-behaviour model: busy for W cycles after an accepted start, then a done pulse.
  int          m_left = 0;
  logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic        p_z = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_left = 0; m_busy = 0; m_done = 0; m_dbz = 0; m_q = '0; m_r = '0;
      end else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dbz = p_z;
        end
      end else begin
        m_done = 0;
        if (bus.div_start) begin
          model_div(bus.div_a, bus.div_b, bus.div_signed, p_q, p_r, p_z);
          if (p_z) begin
            m_done = 1; m_q = p_q; m_r = p_r; m_dbz = 1;
          end else begin
            m_busy = 1; m_left = W;
          end
        end
      end
      #1;
      check("cyc_busy", bus.div_busy, m_busy);
      check("cyc_done", bus.div_done, m_done);
      check("cyc_quot", bus.quot, m_q);
      check("cyc_rem",  bus.rem,  m_r);
      check("cyc_dbz",  bus.div_by_zero, m_dbz);
    end
  end

  task automatic wait_done(input string name, input int exp_lat);
    int cyc = 1;
    while (!bus.div_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_lat"}, cyc, exp_lat);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input logic noise);
    int cyc = 1;
    @(negedge clk);
    bus.div_start = 1'b1; bus.div_a = a; bus.div_b = b; bus.div_signed = s;
    @(negedge clk);
    bus.div_start = 1'b0; bus.div_a = 32'hA5A5_5A5A; bus.div_b = 32'h0000_0003;
    while (!bus.div_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.div_start = noise && (cyc == 5 || cyc == 12);
    end
    check({name, "_lat"}, cyc, (b == '0) ? 1 : W + 1);
    check({name, "_q"}, bus.quot, eq);
    check({name, "_r"}, bus.rem, er);
    check({name, "_dbz"}, bus.div_by_zero, ez);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int dn;
    bus.div_start = 0; bus.div_a = '0; bus.div_b = '0; bus.div_signed = 0;
    repeat (2) @(negedge clk);
    check("rst_quot", bus.quot, 0);
    check("rst_busy", bus.div_busy, 0);
    rst_n = 1'b1;

    do_op("u100_7",  32'd100,      32'd7,        0, 32'd14,       32'd2,    0, 0);
    do_op("umax_1",  32'hFFFF_FFFF, 32'd1,       0, 32'hFFFF_FFFF, 32'd0,   0, 0);
    do_op("u5_9",    32'd5,        32'd9,        0, 32'd0,        32'd5,    0, 0);
    do_op("u0_5",    32'd0,        32'd5,        0, 32'd0,        32'd0,    0, 0);
    do_op("umax_max",32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'd1,      32'd0,    0, 0);
    do_op("u1234_0", 32'd1234,     32'd0,        0, 32'hFFFF_FFFF, 32'd1234, 1, 0);
    do_op("u10_3",   32'd10,       32'd3,        0, 32'd3,        32'd1,    0, 0);
    do_op("u77_10n", 32'd77,       32'd10,       0, 32'd7,        32'd7,    0, 1);

    // Start held high through a whole op and into its done cycle with new operands.
    @(negedge clk);
    bus.div_start = 1'b1; bus.div_a = 32'd20; bus.div_b = 32'd4; bus.div_signed = 0;
    dn = 0;
    while (!bus.div_done && dn < 100) begin @(negedge clk); dn++; end
    check("b2b1_lat", dn, W + 1);
    check("b2b1_q", bus.quot, 5);
    check("b2b1_r", bus.rem, 0);
    bus.div_a = 32'd21; bus.div_b = 32'd4;
    @(negedge clk);
    check("b2b2_busy", bus.div_busy, 1);
    bus.div_start = 1'b0; bus.div_a = 32'd99;
    wait_done("b2b2", W + 1);
    check("b2b2_q", bus.quot, 5);
    check("b2b2_r", bus.rem, 1);

    // Reset mid-run: outputs clear and the aborted op never signals done.
    @(negedge clk);
    bus.div_start = 1'b1; bus.div_a = 32'd1000; bus.div_b = 32'd3;
    @(negedge clk);
    bus.div_start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", bus.div_busy, 0);
    check("mrst_done", bus.div_done, 0);
    check("mrst_quot", bus.quot, 0);
    check("mrst_rem",  bus.rem, 0);
    check("mrst_dbz",  bus.div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.div_done) dn++;
    end
    check("mrst_no_done", dn, 0);
    do_op("u9_2", 32'd9, 32'd2, 0, 32'd4, 32'd1, 0, 0);

`ifdef DIV_SIGNED_EN
    do_op("s-7_2",  32'hFFFF_FFF9, 32'd2,         1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0);
    do_op("s7_-2",  32'd7,         32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'd1,         0, 0);
    do_op("s_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'd0,         0, 0);
    do_op("s-5_0",  32'hFFFF_FFFB, 32'd0,         1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);
    do_op("s0_u",   32'hFFFF_FFF9, 32'd2,         0, 32'h7FFF_FFFC, 32'd1,         0, 0);
`else
    do_op("sflag_ign", 32'hFFFF_FFF9, 32'd2, 1, 32'h7FFF_FFFC, 32'd1, 0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
